// File: rtl/modulo_folder_pkg.sv
// Shared constants, types and FSM encoding for the modulo (self-reset) ADC folder.
package modulo_folder_pkg;

    localparam int unsigned ROWS      = 20;
    localparam int unsigned J         = ROWS - 1;
    localparam int unsigned OUT_RES   = 16;
    localparam int unsigned L         = 4096;
    localparam int unsigned MAX_FOLDS = 7;
    localparam int unsigned FW        = $clog2(MAX_FOLDS + 1) + 1;

    typedef logic signed [OUT_RES-1:0] sample_t;
    typedef logic signed [FW-1:0]      fold_t;

    typedef enum logic [1:0] {
        IDLE,
        FOLD,
        DONE
    } fold_state_e;

    // Signed fold-count width able to hold +/-max_folds
    function automatic int unsigned fold_width(input int unsigned max_folds);
        return $clog2(max_folds + 1) + 1;
    endfunction

endpackage

// File: rtl/modulo_folder_if.sv
// Column request/result bundle between a column producer and the folder.
interface modulo_folder_if #(
    parameter int unsigned ROWS    = modulo_folder_pkg::ROWS,
    parameter int unsigned OUT_RES = modulo_folder_pkg::OUT_RES,
    parameter int unsigned FW      = modulo_folder_pkg::FW
);
    logic                      start;
    logic signed [OUT_RES-1:0] in [ROWS];
    logic signed [OUT_RES-1:0] out [ROWS];
    logic signed [FW-1:0]      folds [ROWS];
    logic                      busy;
    logic                      done;
    logic                      out_valid;
    logic                      ovf;

    modport master (
        output start, in,
        input  out, folds, busy, done, out_valid, ovf
    );

    modport slave (
        input  start, in,
        output out, folds, busy, done, out_valid, ovf
    );
endinterface

// File: rtl/modulo_folder_step.sv
// One folding decision: compare against +/-L, then either a single +/-2L step,
// a saturated result, or the in-range result.
module modulo_folder_step #(
    parameter int unsigned OUT_RES   = modulo_folder_pkg::OUT_RES,
    parameter int unsigned L         = modulo_folder_pkg::L,
    parameter int unsigned MAX_FOLDS = modulo_folder_pkg::MAX_FOLDS,
    parameter int unsigned FW        = modulo_folder_pkg::fold_width(MAX_FOLDS)
) (
    input  logic signed [OUT_RES:0]   acc,
    input  logic signed [FW-1:0]      k,
    output logic signed [OUT_RES:0]   acc_c,
    output logic signed [FW-1:0]      k_c,
    output logic                      more_c,
    output logic signed [OUT_RES-1:0] out_c,
    output logic signed [FW-1:0]      folds_c,
    output logic                      sat_c
);
    localparam int unsigned AW = OUT_RES + 1;
    localparam logic signed [AW-1:0]      L_POS  = AW'(L);
    localparam logic signed [AW-1:0]      L_NEG  = -L_POS;
    localparam logic signed [AW-1:0]      TWO_L  = AW'(2 * L);
    localparam logic signed [FW-1:0]      K_MAX  = FW'(MAX_FOLDS);
    localparam logic signed [FW-1:0]      K_MIN  = -K_MAX;
    localparam logic signed [OUT_RES-1:0] SAT_HI = OUT_RES'(L - 1);
    localparam logic signed [OUT_RES-1:0] SAT_LO = -OUT_RES'(L);

    logic hi;
    logic lo;

    // Fold one step toward [-L, L) or resolve the sample
    always_comb begin
        hi      = (acc >= L_POS);
        lo      = (acc < L_NEG);
        acc_c   = acc;
        k_c     = k;
        more_c  = 1'b0;
        out_c   = acc[OUT_RES-1:0];
        folds_c = k;
        sat_c   = 1'b0;
        if (hi && (k < K_MAX)) begin
            acc_c  = acc - TWO_L;
            k_c    = k + FW'(1);
            more_c = 1'b1;
        end else if (lo && (k > K_MIN)) begin
            acc_c  = acc + TWO_L;
            k_c    = k - FW'(1);
            more_c = 1'b1;
        end else if (hi) begin
            out_c   = SAT_HI;
            folds_c = K_MAX;
            sat_c   = 1'b1;
        end else if (lo) begin
            out_c   = SAT_LO;
            folds_c = K_MIN;
            sat_c   = 1'b1;
        end
    end
endmodule

// File: rtl/modulo_folder.sv
// Sample-serial modulo folder: folds a column of signed samples into [-L, L)
// and records the signed fold count of each sample.
module modulo_folder #(
    parameter int unsigned ROWS      = modulo_folder_pkg::ROWS,
    parameter int unsigned OUT_RES   = modulo_folder_pkg::OUT_RES,
    parameter int unsigned L         = modulo_folder_pkg::L,
    parameter int unsigned MAX_FOLDS = modulo_folder_pkg::MAX_FOLDS
) (
    input logic          clk,
    input logic          reset,
    modulo_folder_if.slave bus
);
    import modulo_folder_pkg::*;

    localparam int unsigned FOLD_W   = fold_width(MAX_FOLDS);
    localparam int unsigned AW       = OUT_RES + 1;
    localparam int unsigned IW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(ROWS - 1);

    fold_state_e               state_q, state_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic signed [AW-1:0]      acc_q, acc_d;
    logic signed [FOLD_W-1:0]  k_q, k_d;
    logic signed [OUT_RES-1:0] in_buf_q [ROWS];
    logic signed [OUT_RES-1:0] in_buf_d [ROWS];
    logic signed [OUT_RES-1:0] out_q [ROWS];
    logic signed [OUT_RES-1:0] out_d [ROWS];
    logic signed [FOLD_W-1:0]  folds_q [ROWS];
    logic signed [FOLD_W-1:0]  folds_d [ROWS];
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      out_valid_q, out_valid_d;
    logic                      ovf_q, ovf_d;

    logic signed [AW-1:0]      step_acc_c;
    logic signed [FOLD_W-1:0]  step_k_c;
    logic                      step_more_c;
    logic signed [OUT_RES-1:0] step_out_c;
    logic signed [FOLD_W-1:0]  step_folds_c;
    logic                      step_sat_c;

    modulo_folder_step #(
        .OUT_RES  (OUT_RES),
        .L        (L),
        .MAX_FOLDS(MAX_FOLDS),
        .FW       (FOLD_W)
    ) u_step (
        .acc    (acc_q),
        .k      (k_q),
        .acc_c  (step_acc_c),
        .k_c    (step_k_c),
        .more_c (step_more_c),
        .out_c  (step_out_c),
        .folds_c(step_folds_c),
        .sat_c  (step_sat_c)
    );

    // Control FSM next state and datapath updates
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        k_d         = k_q;
        in_buf_d    = in_buf_q;
        out_d       = out_q;
        folds_d     = folds_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    in_buf_d    = bus.in;
                    acc_d       = {bus.in[0][OUT_RES-1], bus.in[0]};
                    k_d         = '0;
                    idx_d       = '0;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                    ovf_d       = 1'b0;
                    state_d     = FOLD;
                end
            end
            FOLD: begin
                if (step_more_c) begin
                    acc_d = step_acc_c;
                    k_d   = step_k_c;
                end else begin
                    out_d[idx_q]   = step_out_c;
                    folds_d[idx_q] = step_folds_c;
                    if (step_sat_c) begin
                        ovf_d = 1'b1;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                        acc_d = {in_buf_q[idx_d][OUT_RES-1], in_buf_q[idx_d]};
                        k_d   = '0;
                    end
                end
            end
            DONE: begin
                done_d      = 1'b1;
                busy_d      = 1'b0;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and storage registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            acc_q       <= '0;
            k_q         <= '0;
            in_buf_q    <= '{default: '0};
            out_q       <= '{default: '0};
            folds_q     <= '{default: '0};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            in_buf_q    <= in_buf_d;
            out_q       <= out_d;
            folds_q     <= folds_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.folds     = folds_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: doc/modulo_folder.md
Name: modulo_folder

Overview:
- Encoder-side counterpart of the fold-removal path: emulates a modulo (self-reset) ADC on a column of ROWS signed samples.
- Folds each sample into the centred interval [-L, L) and reports the signed fold count per sample.
- Feeds the fold remover in closed-loop tests, and the reconstruction chain in hardware-in-loop runs, with realistic folded columns plus ground-truth fold counts.
- Division-free: one add/subtract of 2L per cycle, sample-serial.

Parameters:
- ROWS, 20, samples per column (J+1).
- OUT_RES, 16, sample width in bits, signed.
- L, 4096, folding threshold; must satisfy 0 < L < 2^(OUT_RES-2).
- MAX_FOLDS, 7, maximum fold magnitude per sample; fold count width FW = clog2(MAX_FOLDS+1)+1, signed.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- start, in, 1, one-cycle request to fold the column on in.
- in, in, ROWS x OUT_RES signed, unfolded column; sampled only on an accepted start.
- out, out, ROWS x OUT_RES signed, folded column.
- folds, out, ROWS x FW signed, fold count k[i] such that in[i] = out[i] + 2L*k[i] (unless ovf).
- busy, out, 1, high while a column is in progress.
- done, out, 1, one-cycle pulse when out/folds are complete.
- out_valid, out, 1, high from done until the next accepted start.
- ovf, out, 1, sticky per column; set if any sample needs more than MAX_FOLDS folds.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset values: out all 0, folds all 0, busy 0, done 0, out_valid 0, ovf 0; state IDLE.
- Internal accumulator acc is OUT_RES+1 bits signed; adding or subtracting 2L must never wrap.
- IDLE:
  - start=1: latch in into in_buf, acc <= in[0], k <= 0, idx <= 0, busy <= 1, out_valid <= 0, ovf <= 0, go to FOLD.
- FOLD, one action per cycle:
  - acc >= L and k < MAX_FOLDS: acc <= acc - 2L, k <= k+1.
  - acc < -L and k > -MAX_FOLDS: acc <= acc + 2L, k <= k-1.
  - acc >= L and k == MAX_FOLDS: out[idx] <= L-1, folds[idx] <= MAX_FOLDS, ovf <= 1, advance.
  - acc < -L and k == -MAX_FOLDS: out[idx] <= -L, folds[idx] <= -MAX_FOLDS, ovf <= 1, advance.
  - Otherwise (in range): out[idx] <= acc, folds[idx] <= k, advance.
  - Advance: if idx == ROWS-1, go to DONE; else idx <= idx+1, acc <= in_buf[idx+1], k <= 0.
- DONE: done <= 1 for exactly one cycle, busy <= 0, out_valid <= 1, go to IDLE.
- Boundaries:
  - in = -L gives out -L, k 0.
  - in = L gives out -L, k +1.
  - in = L-1 gives out L-1, k 0.
- Latency: sample i costs 1+|k[i]| cycles. With start seen at edge 0, done is high after edge sum(1+|k[i]|)+1. An all-in-range column gives done after edge ROWS+1.
- Outputs are written in place per index; untouched indices hold the previous column's values until overwritten. out_valid marks coherence.
- start while busy is ignored, with no effect on in_buf or state. start in the DONE cycle is also ignored; it is accepted from IDLE only.
- reset mid-column aborts immediately: all outputs go to reset values and no done is issued.
- in changing while busy has no effect.

Decomposition:
- usf_pkg holds:
  - OUT_RES, J, L, MAX_FOLDS constants shared with fold_remover.
  - typedef sample_t (signed OUT_RES).
  - typedef fold_t (signed FW).
  - fold_state_e {IDLE, FOLD, DONE}.
- One natural sub-module, modulo_step: combinational compare against ±L plus the single ±2L update and saturation decision. It is reused by a future pipelined folder.
- Control FSM and storage stay in modulo_folder.

Test Plan:
- All zeros, start pulse -> out all 0, folds all 0, done high after edge 21 (ROWS=20), ovf 0, busy low after done.
- in[0]=5000, in[1]=-5000, in[2]=4096, in[3]=-4096, in[4]=4095, rest 0 -> out[0..4] = -3192, 3192, -4096, -4096, 4095; folds = +1, -1, +1, 0, 0; done after edge 24.
- in[7]=30000 -> out[7]=-2768, folds[7]=+4; in[8]=-30000 -> out[8]=2768, folds[8]=-4; ovf 0.
- MAX_FOLDS=3, in[0]=32767 -> out[0]=4095, folds[0]=+3, ovf=1 held until the next start, which clears it.
- Second start while busy, then reset asserted mid-column -> second start ignored; after reset all outputs 0, no done pulse; a fresh start afterwards completes normally.
- Round trip: random column within ±7L -> fold_remover fed out recovers in exactly, and in[i] == out[i] + 8192*folds[i] for every i.
